// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with one write port and one registered read port.
// Contents are never reset; only the read-data register is.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic                           i_rclr,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [DATA_W-1:0]              i_wdata,
    output logic [DATA_W-1:0]              o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read data holds its value until the next load response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Req/Ack data-memory responder with programmable wait states.
// Optional range/alignment checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wmem,
    input  logic [DATA_W-1:0] Addr,
    input  logic [DATA_W-1:0] Wdata,
    output logic              Ack,
    output logic [DATA_W-1:0] Rdata,
`ifdef DMEM_RANGE_CHECK_EN
    output logic              Err,
`endif
    output logic              Busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic              w_latch;
    logic              r_wmem;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack;
    logic              r_busy;

    logic              w_access;
    logic              w_acc_wmem;
    logic [DATA_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_err;
    logic              w_we;
    logic              w_re;
    logic              w_rclr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ack   <= (w_state_nx == RESP);
            r_busy  <= (w_state_nx != IDLE);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_latch    = 1'b0;
        if (Reset) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Req) begin
                        w_latch    = 1'b1;
                        w_cnt_nx   = CNT_W'(WAIT_CYCLES);
                        w_state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nx = RESP;
                    end
                end
                RESP:    w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // Request fields are captured once at acceptance and frozen until IDLE.
    always_ff @(posedge Clk) begin
        if (w_latch) begin
            r_wmem  <= Wmem;
            r_addr  <= Addr;
            r_wdata <= Wdata;
        end
    end

    // With zero wait states the access shares the acceptance edge, so use the live inputs.
    assign w_acc_wmem  = (r_state == IDLE) ? Wmem  : r_wmem;
    assign w_acc_addr  = (r_state == IDLE) ? Addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? Wdata : r_wdata;
    assign w_access    = (w_state_nx == RESP) && (r_state != RESP);

`ifdef DMEM_RANGE_CHECK_EN
    logic r_err;

    assign w_err = (|w_acc_addr[DATA_W-1:AW+2]) || (|w_acc_addr[1:0]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_access && w_err;
        end
    end

    assign Err = r_err;
`else
    logic w_unused_addr;

    assign w_err         = 1'b0;
    assign w_unused_addr = ^{w_acc_addr[DATA_W-1:AW+2], w_acc_addr[1:0]};
`endif

    assign w_we   = w_access && w_acc_wmem && !w_err;
    assign w_re   = w_access && !w_acc_wmem && !w_err;
    assign w_rclr = w_access && !w_acc_wmem && w_err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_rclr (w_rclr),
        .i_idx  (w_acc_addr[AW+1:2]),
        .i_wdata(w_acc_wdata),
        .o_rdata(Rdata)
    );

    assign Ack  = r_ack;
    assign Busy = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: cycle-counted transaction model plus directed literal checks.
// Expectations follow DMEM_RANGE_CHECK_EN when it is defined.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WCYC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wmem;
    logic [31:0] addr, wdata;
    logic        ack, busy, err;
    logic [31:0] rdata;

    logic        d0_req, d0_wmem;
    logic [31:0] d0_addr, d0_wdata;
    logic        d0_ack, d0_busy, d0_err;
    logic [31:0] d0_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WCYC)) u_dut (
        .Clk(clk), .Reset(rst), .Req(req), .Wmem(wmem), .Addr(addr), .Wdata(wdata),
        .Ack(ack), .Rdata(rdata),
`ifdef DMEM_RANGE_CHECK_EN
        .Err(err),
`endif
        .Busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(clk), .Reset(rst), .Req(d0_req), .Wmem(d0_wmem), .Addr(d0_addr), .Wdata(d0_wdata),
        .Ack(d0_ack), .Rdata(d0_rdata),
`ifdef DMEM_RANGE_CHECK_EN
        .Err(d0_err),
`endif
        .Busy(d0_busy)
    );

`ifndef DMEM_RANGE_CHECK_EN
    assign err    = 1'b0;
    assign d0_err = 1'b0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a >= 32'(DEPTH * 4)) || (a % 4 != 0);
`else
        return (a != a);
`endif
    endfunction

    // Transaction-level model: one request in flight, answered WCYC+1 cycles after acceptance.
    logic [31:0] m_mem [DEPTH];
    bit          m_on = 0;
    bit          m_pend = 0;
    bit          m_wmem, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_ack_cyc = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_on    = 1;
            m_pend  = 0;
            m_rdata = 32'h0;
        end else begin
            if (m_pend && cyc == m_ack_cyc) begin
                m_pend = 0;
            end else if (!m_pend && req) begin
                m_pend    = 1;
                m_ack_cyc = cyc + 1 + WCYC;
                m_wmem    = wmem;
                m_addr    = addr;
                m_wdata   = wdata;
                m_err     = addr_bad(addr);
            end
            if (m_pend && m_ack_cyc == cyc + 1) begin
                int idx;
                idx = int'((m_addr / 4) % DEPTH);
                if (m_err) begin
                    if (!m_wmem) m_rdata = 32'h0;
                end else if (m_wmem) begin
                    m_mem[idx] = m_wdata;
                end else begin
                    m_rdata = m_mem[idx];
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_on) begin
            bit e_ack;
            e_ack = m_pend && (cyc == m_ack_cyc);
            check("ack", 32'(ack), 32'(e_ack));
            check("busy", 32'(busy), 32'(m_pend));
            check("rdata", rdata, m_rdata);
            check("err", 32'(err), 32'(e_ack && m_err));
        end
    end

    // Issue one request from the current negedge; returns at the negedge where Ack is seen.
    task automatic do_req(input bit wm, input logic [31:0] a, input logic [31:0] d,
                          input int first_k, output int lat, output logic [31:0] rd, output logic er);
        lat = -1;
        rd  = 32'h0;
        er  = 1'b0;
        req = 1'b1;
        wmem = wm;
        addr = a;
        wdata = d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat = k;
                rd  = rdata;
                er  = err;
                return;
            end
            if (k == first_k) begin
                addr  = $urandom;
                wdata = $urandom;
                wmem  = 1'($urandom_range(0, 1));
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL ack_timeout: got no Ack within 20 cycles, expected Ack (addr %h)", a);
    endtask

    task automatic idle_gap();
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [31:0] a;
        logic        er;
        bit          hold;
        logic [31:0] lit [3];

        rst = 1'b1; req = 1'b0; wmem = 1'b0; addr = '0; wdata = '0;
        d0_req = 1'b0; d0_wmem = 1'b0; d0_addr = '0; d0_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", 32'(err), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 32'(i * 4), $urandom, 1, lat, rd, er);
            idle_gap();
        end

        // Store then back-to-back load with Req held high.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1, lat, rd, er);
        check("store_latency", 32'(lat), 32'd3);
        do_req(1'b0, 32'h10, 32'h0, 2, lat, rd, er);
        check("b2b_latency", 32'(lat), 32'd4);
        check("load_deadbeef", rd, 32'hDEADBEEF);
        idle_gap();

        do_req(1'b1, 32'h0, 32'h55AA55AA, 1, lat, rd, er);
        idle_gap();
`ifdef DMEM_RANGE_CHECK_EN
        do_req(1'b1, 32'h402, 32'h12345678, 1, lat, rd, er);
        check("range_err_flag", 32'(er), 32'h1);
        check("range_err_latency", 32'(lat), 32'd3);
        idle_gap();
        do_req(1'b0, 32'h0, 32'h0, 1, lat, rd, er);
        check("range_ok_err", 32'(er), 32'h0);
        check("range_mem_kept", rd, 32'h55AA55AA);
`else
        do_req(1'b1, 32'h400, 32'h12345678, 1, lat, rd, er);
        idle_gap();
        do_req(1'b0, 32'h0, 32'h0, 1, lat, rd, er);
        check("wrap_load", rd, 32'h12345678);
`endif
        idle_gap();

        // Reset one cycle after acceptance abandons the store.
        do_req(1'b1, 32'h20, 32'h0BADF00D, 1, lat, rd, er);
        idle_gap();
        req = 1'b1; wmem = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("no_ack_after_wait_reset", 32'(ack), 32'h0);
            @(negedge clk);
        end
        do_req(1'b0, 32'h20, 32'h0, 1, lat, rd, er);
        check("wait_reset_mem_kept", rd, 32'h0BADF00D);
        idle_gap();

        // Reset during the Ack cycle keeps the committed store.
        do_req(1'b1, 32'h24, 32'h600DCAFE, 1, lat, rd, er);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("resp_reset_ack", 32'(ack), 32'h0);
        check("resp_reset_busy", 32'(busy), 32'h0);
        check("resp_reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 32'h24, 32'h0, 1, lat, rd, er);
        check("resp_reset_committed", rd, 32'h600DCAFE);
        idle_gap();

        // Randomized traffic: scrambled inputs while waiting, held or dropped Req.
        hold = 0;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    a = $urandom;
                2, 3:    a = 32'($urandom_range(0, 255)) * 32'd4 + 32'h400 * 32'($urandom_range(0, 7));
                default: a = 32'($urandom_range(0, 255)) * 32'd4;
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, hold ? 2 : 1, lat, rd, er);
            hold = ($urandom_range(0, 2) == 0);
            if (!hold) begin
                req = 1'b0;
                repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            end
        end
        idle_gap();

        // Zero-wait-state instance: Ack every other cycle with Req held high.
        lit[0] = 32'h11111111; lit[1] = 32'h22222222; lit[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            d0_req = 1'b1; d0_wmem = 1'b1; d0_addr = 32'(i * 4); d0_wdata = lit[i];
            @(negedge clk);
            check("w0_store_ack", 32'(d0_ack), 32'h1);
            d0_req = 1'b0;
            @(negedge clk);
        end
        d0_req = 1'b1; d0_wmem = 1'b0; d0_addr = 32'h0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("w0_ack_pattern", 32'(d0_ack), 32'(j % 2 == 0));
            check("w0_busy_pattern", 32'(d0_busy), 32'(j % 2 == 0));
            if (j % 2 == 0) begin
                check("w0_rdata", d0_rdata, lit[j / 2]);
                d0_addr = 32'((j / 2 + 1) * 4);
            end
            if (j == 5) d0_req = 1'b0;
        end
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU's data-memory port: it accepts one load or store request at a time over a Req/Ack handshake, waits a programmable number of cycles, then performs the access and returns a one-cycle Ack with read data. It replaces the zero-latency combinational data memory when the CPU is driven as a handshaking initiator, and sits between the CPU datapath (ALU result as address, Qb as store data) and the word-addressed storage array.

## Interface

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 2, wait states between request acceptance and response; 0 to 15.

Ports:
- Clk  input  1  single clock; everything is updated on its rising edge.
- Reset  input  1  synchronous, active-high.
- Req  input  1  initiator request; held high until Ack is seen.
- Wmem  input  1  1 = store, 0 = load; valid when Req is high.
- Addr  input  32  byte address; valid when Req is high.
- Wdata  input  32  store data; valid when Req is high.
- Ack  output  1  one-cycle response pulse.
- Rdata  output  32  load data; valid in the Ack cycle, held until the next response.
- Busy  output  1  high whenever the state is not IDLE.
- Err  output  1  range/alignment error flag, valid with Ack; present only when DMEM_RANGE_CHECK_EN is defined.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: if Req is high, latch Addr, Wmem and Wdata, and load the counter with WAIT_CYCLES. Next state is WAIT, or RESP when WAIT_CYCLES is 0.
- WAIT: decrement the counter. When the counter reaches 1, next state is RESP.
- RESP: Ack is high for exactly one cycle. Next state is always IDLE.
- The access is performed on the edge entering RESP.
  - Store: mem[index] is set to the latched Wdata. Rdata is unchanged.
  - Load: Rdata is set to mem[index].
- index = latched Addr[log2(DEPTH_WORDS)+1:2]. Addr[1:0] is ignored. Higher address bits wrap modulo DEPTH_WORDS (unless range check is enabled).
- Changes on Req, Addr, Wmem or Wdata after acceptance are ignored until the FSM returns to IDLE.
- The initiator must drop Req in the cycle after Ack, or present a new request. If Req is high in IDLE, that is a new transaction.
- Memory contents are not cleared by Reset.

## Timing

- Reset values: Ack = 0, Busy = 0, Rdata = 0, Err = 0, state = IDLE, counter = 0.
- Latency: Req sampled in IDLE in cycle N gives Ack in cycle N+1+WAIT_CYCLES.
- Busy is high from cycle N+1 through the Ack cycle inclusive.
- Back-to-back throughput: one transaction per WAIT_CYCLES+2 cycles. There is a mandatory IDLE cycle between transactions.
- Reset asserted in WAIT: the transaction is abandoned, no memory write occurs, and no Ack is issued.
- Reset asserted in RESP: the write was already committed. Ack and the other outputs take their reset values in the next cycle.
- Reset has priority over every other transition.

## Configuration

- Macro: DMEM_RANGE_CHECK_EN.
- When defined:
  - An error is flagged if the latched Addr is at least DEPTH_WORDS*4, or if Addr[1:0] is non-zero.
  - On error, the store is suppressed, Rdata is set to 0, and Err = 1 in the Ack cycle.
  - Err is 0 in every other cycle.
  - Latency is unchanged.
- When undefined:
  - The Err port does not exist.
  - Addresses wrap as above and misalignment is ignored.

## Structure

- Shared package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the data width constant (32);
  - the counter width constant (4).
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage;
  - one write port and one registered read port, both on Clk;
  - write enable and index driven by the FSM;
  - no reset of contents.

## Test plan

- WAIT_CYCLES=2: store 0xDEADBEEF to Addr 0x10, then load Addr 0x10. Each Ack arrives 3 cycles after Req is sampled, and the load returns Rdata = 0xDEADBEEF.
- WAIT_CYCLES=0: back-to-back loads with Req held high. Ack pulses every 2 cycles, and Busy toggles 1,0,1,0.
- Wrap: DEPTH_WORDS=256, store 0x12345678 to Addr 0x400. A load from Addr 0x000 returns 0x12345678 (macro undefined).
- Reset in WAIT: store 0xAAAA5555 to Addr 0x20, then assert Reset one cycle after acceptance. No Ack is seen, and a later load of 0x20 returns the prior value.
- Input change during WAIT: Addr and Wdata are altered after acceptance. The access uses the latched values.
- DMEM_RANGE_CHECK_EN defined:
  - store to Addr 0x402 gives Ack with Err = 1, and memory is unchanged;
  - a following valid load gives Err = 0.
